sys_bus_responder: RTL
======================

Name: sys_bus_responder

Overview:
- System-space slave on the pipeline's sys bus, answering the memory stage's sys_read/sys_write requests.
- Contains:
  - an ID register;
  - a scratch register;
  - a programmable cycle timer with compare match and interrupt;
  - an output FIFO drained through a valid/ready stream port.
- Sits beside the core top level, wired to its sys_* bus outputs; drives sys_r_line back to it.

Parameters:
- BASE, 32'hFFFF_0000, window base; only addr[31:8] is compared.
- ID_VALUE, 32'h4350_0001, value returned by ID register.
- FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- sys_r_addr  input  32  read byte address.
- sys_read  input  1  read strobe, one cycle per access.
- sys_r_line  output  32  read data.
- sys_w_addr  input  32  write byte address.
- sys_w_line  input  32  write data.
- sys_write  input  1  write strobe.
- exc  output  1  bad-access pulse.
- irq  output  1  timer interrupt level.
- out_data  output  32  FIFO head word.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts head.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: all registers 0, FIFO empty, sys_r_line=0, exc=0, irq=0, out_valid=0, out_data=0.
- Reset mid-operation discards FIFO contents and any in-flight read.
- Decode: hit when addr[31:8]==BASE[31:8]. Offset = addr[7:0].
- Register map:
  - 0x00 ID: RO.
  - 0x04 SCRATCH: RW.
  - 0x08 TCNT: RW.
  - 0x0C TCMP: RW.
  - 0x10 TCTRL: RW; bit0 en, bit1 autoreload, bit2 irq_en; other bits read 0.
  - 0x14 TSTAT: bit0 match; write 1 clears.
  - 0x18 FIFO_DATA: WO; reads return 0.
  - 0x1C FIFO_STAT: bits[FIFO_AW:0] count, bit16 empty, bit17 full, bit18 overflow. Writing 1 to bit18 clears it; other bits are RO.
- Read timing: sys_r_line is registered and valid the cycle after sys_read. It holds its value when sys_read=0.
- Read misses: a read outside the window, or a bad access, returns 0.
- Bad access: hit with offset>=0x20 or addr[1:0]!=0, on either port. exc=1 for exactly the cycle after. The write is ignored.
- Writes outside the window are ignored silently.
- Simultaneous read and write to the same register: the read returns the pre-write value.
- Timer:
  - When en=1, TCNT increments by 1 each cycle, wrapping 32'hFFFF_FFFF to 0.
  - In a cycle where en=1 and TCNT==TCMP: match<=1. If autoreload=1, TCNT<=0 next instead of +1.
  - A bus write to TCNT overrides increment and reload that cycle.
  - A W1C of match in the same cycle as a new match leaves match=1 (set wins).
  - irq = match & irq_en, registered.
- FIFO:
  - Show-ahead: out_data = head word, out_valid = !empty.
  - Pop when out_valid & out_ready.
  - Push on a valid write to FIFO_DATA.
  - Full + push without pop: data dropped, overflow<=1 (sticky).
  - Full + push + pop in the same cycle: both happen, count unchanged, no overflow.
  - Empty + push: word visible on out_data the next cycle. No bypass.
  - Pointers wrap mod 2**FIFO_AW. Count ranges 0..2**FIFO_AW.
- FIFO_STAT read reflects state before same-cycle push/pop.

Test Plan:
- Reset, then read 0xFFFF0000 -> sys_r_line=32'h43500001 one cycle after sys_read. Read 0xFFFF0004 -> 0. exc stays 0.
- Write SCRATCH=32'hDEADBEEF, then same-cycle read+write SCRATCH with 32'h1 -> read returns DEADBEEF. Next read returns 1.
- TCMP=5, TCTRL=3 (en, autoreload), TSTAT cleared -> match sets when TCNT==5, TCNT returns to 0, sequence repeats every 6 cycles. With TCTRL=7, irq=1 one cycle after match. W1C TSTAT drops irq.
- Push 9 words with out_ready=0 and FIFO_AW=3 -> FIFO_STAT: count=8, full=1, overflow=1, word 9 lost. Raise out_ready -> words 1..8 drained in order, then out_valid=0 and empty=1.
- FIFO full, push word X with out_ready=1 in the same cycle -> head popped, X accepted, count stays 8, overflow unchanged.
- Read 0xFFFF0020, write 0xFFFF0006, read 0x00001000 -> exc pulses 1 cycle for the first two only. The third returns 0 with no exc. No register changes.

Source files
------------

// File: rtl/sys_bus_responder.sv
// sys_bus_responder: system-space slave on the sys bus.
// Holds an ID register, a scratch register, a cycle timer with compare match
// and interrupt, and a show-ahead output FIFO drained over a valid/ready port.
// Reads are registered and valid the cycle after sys_read.
module sys_bus_responder #(
    parameter logic [31:0] BASE     = 32'hFFFF_0000,
    parameter logic [31:0] ID_VALUE = 32'h4350_0001,
    parameter int          FIFO_AW  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] sys_r_addr,
    input  logic        sys_read,
    output logic [31:0] sys_r_line,
    input  logic [31:0] sys_w_addr,
    input  logic [31:0] sys_w_line,
    input  logic        sys_write,
    output logic        exc,
    output logic        irq,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int                 DEPTH     = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0]   DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

    localparam logic [7:0] OFF_ID      = 8'h00;
    localparam logic [7:0] OFF_SCRATCH = 8'h04;
    localparam logic [7:0] OFF_TCNT    = 8'h08;
    localparam logic [7:0] OFF_TCMP    = 8'h0C;
    localparam logic [7:0] OFF_TCTRL   = 8'h10;
    localparam logic [7:0] OFF_TSTAT   = 8'h14;
    localparam logic [7:0] OFF_FDATA   = 8'h18;
    localparam logic [7:0] OFF_FSTAT   = 8'h1C;

    // Address falls inside the 256-byte window
    function automatic logic addr_hit(input logic [31:0] addr);
        return addr[31:8] == BASE[31:8];
    endfunction

    // Hit on an unmapped offset or a misaligned word address
    function automatic logic addr_bad(input logic [31:0] addr);
        return addr_hit(addr) && ((addr[7:0] >= 8'h20) || (addr[1:0] != 2'b00));
    endfunction

    logic [31:0]        scratch_r;
    logic [31:0]        tcnt_r;
    logic [31:0]        tcmp_r;
    logic [2:0]         tctrl_r;
    logic               match_r;
    logic               irq_r;
    logic [31:0]        r_line_r;
    logic               exc_r;
    logic [31:0]        fifo_mem_r [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r;
    logic [FIFO_AW-1:0] rd_ptr_r;
    logic [FIFO_AW:0]   count_r;
    logic               overflow_r;

    logic [7:0]  r_off_s;
    logic [7:0]  w_off_s;
    logic        r_ok_s;
    logic        w_ok_s;
    logic        exc_s;
    logic        fifo_empty_s;
    logic        fifo_full_s;
    logic        pop_s;
    logic        push_req_s;
    logic        push_s;
    logic        ovf_set_s;
    logic        timer_hit_s;
    logic [31:0] tcnt_nxt_s;
    logic [31:0] fifo_stat_s;
    logic [31:0] rdata_s;

    assign r_off_s      = sys_r_addr[7:0];
    assign w_off_s      = sys_w_addr[7:0];
    assign r_ok_s       = sys_read && addr_hit(sys_r_addr) && !addr_bad(sys_r_addr);
    assign w_ok_s       = sys_write && addr_hit(sys_w_addr) && !addr_bad(sys_w_addr);
    assign exc_s        = (sys_read && addr_bad(sys_r_addr)) || (sys_write && addr_bad(sys_w_addr));
    assign fifo_empty_s = (count_r == '0);
    assign fifo_full_s  = (count_r == DEPTH_CNT);
    assign pop_s        = !fifo_empty_s && out_ready;
    assign push_req_s   = w_ok_s && (w_off_s == OFF_FDATA);
    // A push into a full FIFO is only accepted when the head leaves the same cycle
    assign push_s       = push_req_s && (!fifo_full_s || pop_s);
    assign ovf_set_s    = push_req_s && fifo_full_s && !pop_s;
    assign timer_hit_s  = tctrl_r[0] && (tcnt_r == tcmp_r);

    // Timer next value: bus write beats reload, reload beats increment
    always_comb begin
        tcnt_nxt_s = tcnt_r;
        if (w_ok_s && (w_off_s == OFF_TCNT)) begin
            tcnt_nxt_s = sys_w_line;
        end else if (timer_hit_s && tctrl_r[1]) begin
            tcnt_nxt_s = 32'h0000_0000;
        end else if (tctrl_r[0]) begin
            tcnt_nxt_s = tcnt_r + 32'd1;
        end else begin
            tcnt_nxt_s = tcnt_r;
        end
    end

    // FIFO status word as seen before this cycle's push/pop
    always_comb begin
        fifo_stat_s            = 32'h0000_0000;
        fifo_stat_s[FIFO_AW:0] = count_r;
        fifo_stat_s[16]        = fifo_empty_s;
        fifo_stat_s[17]        = fifo_full_s;
        fifo_stat_s[18]        = overflow_r;
    end

    // Read data mux over the register map (pre-write values)
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (r_off_s)
            OFF_ID:      rdata_s = ID_VALUE;
            OFF_SCRATCH: rdata_s = scratch_r;
            OFF_TCNT:    rdata_s = tcnt_r;
            OFF_TCMP:    rdata_s = tcmp_r;
            OFF_TCTRL:   rdata_s = {29'd0, tctrl_r};
            OFF_TSTAT:   rdata_s = {31'd0, match_r};
            OFF_FSTAT:   rdata_s = fifo_stat_s;
            default:     rdata_s = 32'h0000_0000;
        endcase
    end

    // Registered read data and bad-access pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_line_r <= 32'h0000_0000;
            exc_r    <= 1'b0;
        end else begin
            exc_r <= exc_s;
            if (sys_read) begin
                r_line_r <= r_ok_s ? rdata_s : 32'h0000_0000;
            end
        end
    end

    // Writable registers, timer and interrupt
    always_ff @(posedge clk) begin
        if (rst) begin
            scratch_r <= 32'h0000_0000;
            tcnt_r    <= 32'h0000_0000;
            tcmp_r    <= 32'h0000_0000;
            tctrl_r   <= 3'b000;
            match_r   <= 1'b0;
            irq_r     <= 1'b0;
        end else begin
            tcnt_r <= tcnt_nxt_s;
            irq_r  <= match_r && tctrl_r[2];
            if (w_ok_s && (w_off_s == OFF_SCRATCH)) begin
                scratch_r <= sys_w_line;
            end
            if (w_ok_s && (w_off_s == OFF_TCMP)) begin
                tcmp_r <= sys_w_line;
            end
            if (w_ok_s && (w_off_s == OFF_TCTRL)) begin
                tctrl_r <= sys_w_line[2:0];
            end
            // A new match wins over a same-cycle clear
            if (timer_hit_s) begin
                match_r <= 1'b1;
            end else if (w_ok_s && (w_off_s == OFF_TSTAT) && sys_w_line[0]) begin
                match_r <= 1'b0;
            end
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (w_ok_s && (w_off_s == OFF_FSTAT) && sys_w_line[18]) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // FIFO storage; contents are don't-care outside the valid window
    always_ff @(posedge clk) begin
        if (!rst && push_s) begin
            fifo_mem_r[wr_ptr_r] <= sys_w_line;
        end
    end

    assign sys_r_line = r_line_r;
    assign exc        = exc_r;
    assign irq        = irq_r;
    assign out_valid  = !fifo_empty_s;
    assign out_data   = fifo_empty_s ? 32'h0000_0000 : fifo_mem_r[rd_ptr_r];

endmodule
